// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input synchronizer, mid-bit sampling and an output buffer.
// Define UART_RX_FIFO_EN for a 4-entry FIFO buffer; by default a single holding register is used.
module uart_rx #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  localparam logic [15:0] HALF_LD = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_LD = 16'(BAUD_DIV - 1);

  logic        rx_meta_q, rxs_q;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        brk_q, brk_d;
  logic        frame_err_q, overrun_q;
  logic        cnt_zero, push, fe_d, ov_d, pop;

  assign cnt_zero  = (cnt_q == 16'd0);
  assign pop       = valid && ready;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rxs_q) state_d = S_START;
      S_START: if (cnt_zero) state_d = rxs_q ? S_IDLE : S_DATA;
      S_DATA:  if (cnt_zero && idx_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (rxs_q && (brk_q || cnt_zero)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // brk_q marks a bad stop bit already reported; wait for the line to return high
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    brk_d   = brk_q;
    push    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      S_IDLE: if (!rxs_q) cnt_d = HALF_LD;
      S_START: begin
        if (!cnt_zero) cnt_d = cnt_q - 16'd1;
        else if (!rxs_q) begin
          cnt_d = FULL_LD;
          idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (!cnt_zero) cnt_d = cnt_q - 16'd1;
        else begin
          shift_d[idx_q] = rxs_q;
          cnt_d          = FULL_LD;
          idx_d          = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (brk_q) begin
          if (rxs_q) brk_d = 1'b0;
        end else if (!cnt_zero) cnt_d = cnt_q - 16'd1;
        else if (rxs_q) push = 1'b1;
        else begin
          fe_d  = 1'b1;
          brk_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= 16'd0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      brk_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      brk_q       <= brk_d;
      frame_err_q <= fe_d;
      overrun_q   <= ov_d;
    end
  end

`ifdef UART_RX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wptr_q, rptr_q;
  logic [2:0] fcnt_q;
  logic       full, accept;

  assign full   = (fcnt_q == 3'd4);
  assign accept = push && (!full || pop);
  assign ov_d   = push && full && !pop;
  assign valid  = (fcnt_q != 3'd0);
  assign data   = mem_q[rptr_q];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
      wptr_q <= 2'd0;
      rptr_q <= 2'd0;
      fcnt_q <= 3'd0;
    end else begin
      if (accept) begin
        mem_q[wptr_q] <= shift_q;
        wptr_q        <= wptr_q + 2'd1;
      end
      if (pop) rptr_q <= rptr_q + 2'd1;
      fcnt_q <= fcnt_q + {2'b00, accept} - {2'b00, pop};
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_vld_q, accept;

  assign accept = push && (!hold_vld_q || pop);
  assign ov_d   = push && hold_vld_q && !pop;
  assign valid  = hold_vld_q;
  assign data   = hold_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
    end else if (accept) begin
      hold_q     <= shift_q;
      hold_vld_q <= 1'b1;
    end else if (pop) begin
      hold_vld_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx at BAUD_DIV = 8; expectations come from frame timing and buffer capacity.
module tb_uart_rx;
  localparam int BD = 8;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  uart_rx #(.BAUD_DIV(BD)) dut (
    .clk(clk), .resetn(resetn), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation side: cycles with valid, popped bytes, pulse counts and pulse widths
  int         fe_cnt = 0, ov_cnt = 0, width_viol = 0;
  logic       fe_prev = 1'b0, ov_prev = 1'b0;
  logic [7:0] recv[$];
  int         vq[$];
  always @(negedge clk) begin
    if (valid) vq.push_back(cyc);
    if (valid && ready) recv.push_back(data);
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if ((frame_err && fe_prev) || (overrun && ov_prev)) width_viol++;
    fe_prev = frame_err;
    ov_prev = overrun;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start bit begins just after the posedge where cyc == c0; each bit lasts BD clocks
  task automatic send(input logic [7:0] b, input logic stop, output int c0);
    @(posedge clk); #1;
    c0 = cyc;
    rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (BD) @(posedge clk);
    #1 rx = stop;
    repeat (BD) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  function automatic logic [31:0] qbyte(input int idx);
    return (idx < recv.size()) ? 32'(recv[idx]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    int         c0, fe0, ov0, r0, v0, stop_edge;
    logic [7:0] exp_q[$];
    logic [7:0] b;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    #2 resetn = 1'b1;

    // ready while idle does nothing
    ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_ready_valid", 32'(valid), 32'd0);
    chk("idle_ready_data", 32'(data), 32'h00);

    // 0x55: 2 sync stages, 1 detect edge, half-bit, 9 full bits to stop sample
    r0 = recv.size(); v0 = vq.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    send(8'h55, 1'b1, c0);
    stop_edge = c0 + 3 + BD / 2 + 9 * BD;
    repeat (4) @(posedge clk);
    #1;
    chk("p55_valid_cycles", vq.size() - v0, 32'd1);
    chk("p55_latency", (vq.size() > v0) ? vq[v0] : -1, stop_edge);
    chk("p55_data", qbyte(r0), 32'h55);
    chk("p55_frame_err", fe_cnt - fe0, 32'd0);
    chk("p55_overrun", ov_cnt - ov0, 32'd0);

    // False start: two low cycles only
    v0 = vq.size(); fe0 = fe_cnt;
    @(posedge clk); #1 rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    repeat (5 * BD) @(posedge clk);
    #1;
    chk("false_start_valid", vq.size() - v0, 32'd0);
    chk("false_start_fe", fe_cnt - fe0, 32'd0);

    // Bad stop bit, then a good frame
    r0 = recv.size(); v0 = vq.size(); fe0 = fe_cnt;
    send(8'hA3, 1'b0, c0);
    repeat (2 * BD) @(posedge clk);
    #1;
    chk("ferr_pulses", fe_cnt - fe0, 32'd1);
    chk("ferr_valid", vq.size() - v0, 32'd0);
    send(8'h3C, 1'b1, c0);
    repeat (4) @(posedge clk);
    #1;
    chk("after_ferr_count", recv.size() - r0, 32'd1);
    chk("after_ferr_data", qbyte(r0), 32'h3C);
    chk("after_ferr_fe", fe_cnt - fe0, 32'd1);

    // Buffer fill with no consumer: first CAP bytes kept, rest dropped
    ready = 1'b0;
    r0 = recv.size(); ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, c0);
    repeat (4) @(posedge clk);
    #1;
    chk("fill_overruns", ov_cnt - ov0, 32'(5 - CAP));
    chk("fill_valid", 32'(valid), 32'd1);
    chk("fill_head", 32'(data), 32'h01);
    chk("fill_no_pop", recv.size() - r0, 32'd0);
    ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    ready = 1'b0;
    chk("drain_count", recv.size() - r0, 32'(CAP));
    for (int i = 0; i < CAP; i++) chk($sformatf("drain_%0d", i), qbyte(r0 + i), 32'(i + 1));
    chk("drain_valid", 32'(valid), 32'd0);

    // Reset during data bit 4 of 0xFF
    ready = 1'b1;
    r0 = recv.size(); fe0 = fe_cnt;
    @(posedge clk); #1 rx = 1'b0;
    repeat (BD) @(posedge clk);
    #1 rx = 1'b1;
    repeat (4 * BD + BD / 2) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_data", 32'(data), 32'h00);
    repeat (2) @(posedge clk);
    #4 resetn = 1'b1;
    repeat (6 * BD) @(posedge clk);
    send(8'h81, 1'b1, c0);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_count", recv.size() - r0, 32'd1);
    chk("midrst_byte", qbyte(r0), 32'h81);
    chk("midrst_fe", fe_cnt - fe0, 32'd0);

    // Random bytes with random idle gaps; every byte must arrive in order
    r0 = recv.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send(b, 1'b1, c0);
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("rand_count", recv.size() - r0, 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) chk($sformatf("rand_%0d", i), qbyte(r0 + i), 32'(exp_q[i]));
    chk("rand_fe", fe_cnt - fe0, 32'd0);
    chk("rand_ov", ov_cnt - ov0, 32'd0);

    chk("pulse_width", width_viol, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
